memory_module2: RTL and testbench

Read-only 32-word × 16-bit memory with a byte-oriented 16-bit address and one registered read port. It holds a fixed, reset-loaded image and serves as a small instruction/constant store in the datapath. The address comes from the datapath address bus; `readData` feeds the downstream datapath registers.

---
 rtl/memory_module2_pkg.sv | 18 +
 rtl/memory_module2_if.sv | 11 +
 rtl/memory_module2.sv | 51 +++++
 tb/tb_memory_module2.sv | 104 ++++++++++
 4 files changed

// File: rtl/memory_module2_pkg.sv
// rtl/memory_module2_pkg.sv - geometry constants and reset image for the 32x16 read-only store
package memory_module2_pkg;

   localparam int MEM_DEPTH  = 32;
   localparam int MEM_WIDTH  = 16;
   localparam int ADDR_WIDTH = 16;

   localparam logic [MEM_WIDTH-1:0] IMAGE_BASE = 16'hA000;
   localparam logic [MEM_WIDTH-1:0] IMAGE_STEP = 16'h0101;

   // Image word k wraps modulo 2^16, so the product is deliberately kept at 16 bits.
   function automatic logic [MEM_WIDTH-1:0] image_word(input int unsigned k);
      logic [MEM_WIDTH-1:0] idx;
      idx = k[MEM_WIDTH-1:0];
      return IMAGE_BASE + idx * IMAGE_STEP;
   endfunction

endpackage

// File: rtl/memory_module2_if.sv
// rtl/memory_module2_if.sv - read-port bus between datapath address source and the store
interface memory_module2_if;
   import memory_module2_pkg::*;

   logic [ADDR_WIDTH-1:0] readAddress;
   logic [MEM_WIDTH-1:0]  readData;

   modport master (output readAddress, input readData);
   modport slave  (input readAddress, output readData);

endinterface

// File: rtl/memory_module2.sv
// rtl/memory_module2.sv - reset-loaded 32x16 ROM with registered read; MEM_RANGE_CHECK_EN zeroes reads at or above 0x0040
module memory_module2
   import memory_module2_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   memory_module2_if.slave        bus
);

   logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
   logic [MEM_WIDTH-1:0] read_data;
   logic [4:0]           word_index;
   logic                 out_of_range;

   // Bytes pair into words, so bit 0 never selects anything.
   assign word_index = bus.readAddress[5:1];

`ifdef MEM_RANGE_CHECK_EN
   assign out_of_range = |bus.readAddress[ADDR_WIDTH-1:6];
   logic unused_addr_bits;
   assign unused_addr_bits = bus.readAddress[0];
`else
   // Upper address bits alias onto the 32-word space and carry no meaning here.
   assign out_of_range = 1'b0;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.readAddress[ADDR_WIDTH-1:6], bus.readAddress[0]};
`endif

   // Storage reloads the image on every reset; there is no other way to change it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < MEM_DEPTH; k++) begin
            mem[k[4:0]] <= image_word(k);
         end
      end
   end

   // Output register: cleared in reset, otherwise one word per edge with no bubbles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         read_data <= '0;
      end else if (out_of_range) begin
         read_data <= '0;
      end else begin
         read_data <= mem[word_index];
      end
   end

   assign bus.readData = read_data;

endmodule

// File: tb/tb_memory_module2.sv
// tb/tb_memory_module2.sv - self-checking bench for memory_module2, directed plus randomized reads
module tb_memory_module2;

   logic clk;
   logic reset;
   int   passed;
   int   total;

   memory_module2_if bus ();

   memory_module2 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: word k = 0xA000 + k*0x0101 mod 2^16, k = (addr / 2) mod 32.
   function automatic logic [15:0] model(input bit rst_level, input logic [15:0] addr);
      int k;
      int v;
      if (!rst_level) return 16'h0000;
`ifdef MEM_RANGE_CHECK_EN
      if (addr >= 16'h0040) return 16'h0000;
`endif
      k = (int'(addr) / 2) % 32;
      v = (40960 + k * 257) % 65536;
      return v[15:0];
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drive between edges, then sample 1 ns after the edge that consumes the inputs.
   task automatic step(input bit rst_level, input logic [15:0] addr);
      @(negedge clk);
      reset = rst_level;
      bus.readAddress = addr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] addr;
      bit          rst_level;
      logic [15:0] exp_prev;

      passed = 0;
      total  = 0;
      reset  = 1'b0;
      bus.readAddress = 16'h0000;

      step(1'b0, 16'h0000); check("reset_state", bus.readData, 16'h0000);
      step(1'b1, 16'h0000); check("first_read", bus.readData, 16'hA000);

      step(1'b1, 16'h0028); check("addr_0028", bus.readData, 16'hB414);
      step(1'b1, 16'h0000); check("addr_0000", bus.readData, 16'hA000);
      step(1'b1, 16'h0032); check("addr_0032", bus.readData, 16'hB919);
      step(1'b1, 16'h0029); check("odd_0029", bus.readData, 16'hB414);
      step(1'b1, 16'h003E); check("last_003E", bus.readData, 16'hBF1F);
      step(1'b1, 16'h0001); check("odd_0001", bus.readData, 16'hA000);

      step(1'b1, 16'h0068);
`ifdef MEM_RANGE_CHECK_EN
      check("range_0068", bus.readData, 16'h0000);
`else
      check("alias_0068", bus.readData, 16'hB414);
`endif

      step(1'b1, 16'h0032); check("pre_midreset", bus.readData, 16'hB919);
      step(1'b0, 16'h0032); check("midreset", bus.readData, 16'h0000);
      step(1'b1, 16'h0032); check("post_midreset", bus.readData, 16'hB919);

      // Address moves with no edge in between: output must hold.
      #2 bus.readAddress = 16'h0000;
      #1 check("hold_between_edges", bus.readData, 16'hB919);
      @(posedge clk); #1;
      check("after_hold_edge", bus.readData, 16'hA000);

      // Randomized reads, occasional resets and high-address bits.
      exp_prev = 16'hA000;
      for (int i = 0; i < 200; i++) begin
         rst_level = ($urandom_range(0, 15) != 0);
         addr = 16'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) addr = 16'($urandom);
         step(rst_level, addr);
         check($sformatf("rand_%0d_a%04h_r%0d", i, addr, rst_level), bus.readData, model(rst_level, addr));
         exp_prev = model(rst_level, addr);
         if ($urandom_range(0, 7) == 0) begin
            #2 bus.readAddress = 16'($urandom);
            #1 check($sformatf("rand_hold_%0d", i), bus.readData, exp_prev);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
